// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: RV32M multi-cycle multiply/divide unit (pipelined multiply, 1-bit/cycle restoring divide); ports i_clk/i_rst_n, i_ce/i_funct3/i_rs1/i_rs2/i_rd_addr op in, i_stall/i_flush control, o_stall/o_ce/o_rd/o_rd_addr/o_wr_rd result out
module rv32m_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ce,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_ce,
  output logic [XLEN-1:0] o_rd,
  output logic [4:0]      o_rd_addr,
  output logic            o_wr_rd
);
  localparam int CW = $clog2(XLEN > MUL_LATENCY ? XLEN : MUL_LATENCY) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic neg_q, neg_r;
  logic [XLEN-1:0] q, r, dvs;
  logic [2*XLEN-1:0] p [MUL_LATENCY];
  logic accept, a_sgn, b_sgn, sgn_div, dz, ovf, ge;
  logic [XLEN:0] a_ext, b_ext, shifted;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mag_a, mag_b, diff, q_nx, r_nx, quo, rem, spec_res, mul_res;
  always_comb begin
    accept = state == IDLE && i_ce && !i_flush;
    a_sgn = i_funct3 == 3'd1 || i_funct3 == 3'd2;
    b_sgn = i_funct3 == 3'd1;
    a_ext = {a_sgn & i_rs1[XLEN-1], i_rs1};
    b_ext = {b_sgn & i_rs2[XLEN-1], i_rs2};
    prod = {{(XLEN-1){a_ext[XLEN]}}, a_ext} * {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    sgn_div = !i_funct3[0];
    dz = i_rs2 == '0;
    ovf = sgn_div && i_rs1 == MIN && i_rs2 == '1;
    spec_res = dz ? (i_funct3[1] ? i_rs1 : '1) : (i_funct3[1] ? '0 : i_rs1);
    mag_a = sgn_div && i_rs1[XLEN-1] ? -i_rs1 : i_rs1;
    mag_b = sgn_div && i_rs2[XLEN-1] ? -i_rs2 : i_rs2;
    shifted = {r, q[XLEN-1]};
    ge = shifted >= {1'b0, dvs};
    diff = shifted[XLEN-1:0] - dvs;
    r_nx = ge ? diff : shifted[XLEN-1:0];
    q_nx = {q[XLEN-2:0], ge};
    quo = neg_q ? -q_nx : q_nx;
    rem = neg_r ? -r_nx : r_nx;
    mul_res = op == 2'd0 ? p[MUL_LATENCY-1][XLEN-1:0] : p[MUL_LATENCY-1][2*XLEN-1:XLEN];
    o_stall = accept || state == MUL || state == DIV || (state == DONE && i_stall);
    o_wr_rd = o_ce && o_rd_addr != '0;
  end
  // p[0] is loaded from the raw inputs at accept so the chain end is valid on the last MUL cycle
  always_ff @(posedge i_clk) begin
    if (accept) p[0] <= prod;
    for (int k = 1; k < MUL_LATENCY; k++) p[k] <= p[k-1];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      o_ce <= 1'b0;
      o_rd <= '0;
      o_rd_addr <= '0;
    end else if (i_flush) begin
      state <= IDLE;
      o_ce <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_ce) begin
          op <= i_funct3[1:0];
          o_rd_addr <= i_rd_addr;
          q <= mag_a;
          dvs <= mag_b;
          r <= '0;
          neg_q <= sgn_div && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
          neg_r <= sgn_div && i_rs1[XLEN-1];
          if (!i_funct3[2]) begin
            state <= MUL;
            cnt <= CW'(MUL_LATENCY - 1);
          end else if (dz || ovf) begin
            state <= DONE;
            o_ce <= 1'b1;
            o_rd <= spec_res;
          end else begin
            state <= DIV;
            cnt <= CW'(XLEN - 1);
          end
        end
        MUL: if (cnt == '0) begin
          state <= DONE;
          o_ce <= 1'b1;
          o_rd <= mul_res;
        end else cnt <= cnt - 1'b1;
        DIV: begin
          q <= q_nx;
          r <= r_nx;
          if (cnt == '0) begin
            state <= DONE;
            o_ce <= 1'b1;
            o_rd <= op[1] ? rem : quo;
          end else cnt <= cnt - 1'b1;
        end
        DONE: if (!i_stall) begin
          state <= IDLE;
          o_ce <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
